// File: rtl/local_eject_rx_if.sv
// rtl/local_eject_rx_if.sv - router-facing flit input and PE-facing valid/ready output of the eject receiver
interface local_eject_rx_if #(
    parameter int FLIT_W = 8
);
    logic [FLIT_W-1:0] flit_in;
    logic              flit_wr;
    logic              buf_full;
    logic              pe_valid;
    logic [FLIT_W-1:0] pe_data;
    logic              pe_ready;

    modport master (
        output flit_in, flit_wr, pe_ready,
        input  buf_full, pe_valid, pe_data
    );

    modport slave (
        input  flit_in, flit_wr, pe_ready,
        output buf_full, pe_valid, pe_data
    );
endinterface

// File: rtl/local_eject_rx.sv
// rtl/local_eject_rx.sv - local-port ejection receiver: filters flits for NODE_ID, FIFO to PE, saturating stats
module local_eject_rx #(
    parameter int FLIT_W  = 8,
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    local_eject_rx_if.slave     bus,
    output logic [CNT_W-1:0]    rx_count,
    output logic [CNT_W-1:0]    misroute_count,
    output logic [CNT_W-1:0]    drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic [AW:0]       occ_next;
    logic              full_q;

    logic flit_live;
    logic addr_hit;
    logic cand;
    logic misroute;
    logic pop;
    logic wr_en;
    logic drop;

    assign flit_live = bus.flit_wr & bus.flit_in[FLIT_W-1];
    assign addr_hit  = (bus.flit_in[1:0] == NODE_ID[1:0]);
    assign cand      = flit_live & addr_hit;
    assign misroute  = flit_live & ~addr_hit;

    assign bus.pe_valid = (occ != '0);
    assign bus.pe_data  = bus.pe_valid ? mem[rd_ptr] : '0;
    assign bus.buf_full = full_q;

    // A full FIFO still accepts when the head leaves on the same edge.
    assign pop   = bus.pe_valid & bus.pe_ready;
    assign wr_en = cand & ((occ != OCC_FULL) | pop);
    assign drop  = cand & ~wr_en;

    always_comb begin
        occ_next = occ;
        if (wr_en && !pop) begin
            occ_next = occ + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            occ_next = occ - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.flit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            full_q         <= 1'b0;
            rx_count       <= '0;
            misroute_count <= '0;
            drop_count     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ    <= occ_next;
            full_q <= (occ_next == OCC_FULL);
            if (wr_en && rx_count != '1) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (misroute && misroute_count != '1) begin
                misroute_count <= misroute_count + CNT_W'(1);
            end
            if (drop && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_local_eject_rx.sv
// tb/tb_local_eject_rx.sv - directed self-checking bench for local_eject_rx (NODE_ID=1 and a CNT_W=4 instance)
module tb_local_eject_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    local_eject_rx_if #(.FLIT_W(8)) bus ();
    local_eject_rx_if #(.FLIT_W(8)) bus2 ();

    logic [7:0] rx_count, misroute_count, drop_count;
    logic [3:0] rx2, mis2, drop2;

    local_eject_rx #(.FLIT_W(8), .NODE_ID(1), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .rx_count(rx_count), .misroute_count(misroute_count), .drop_count(drop_count)
    );

    local_eject_rx #(.FLIT_W(8), .NODE_ID(2), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .rx_count(rx2), .misroute_count(mis2), .drop_count(drop2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] f);
        bus.flit_wr = 1'b1;
        bus.flit_in = f;
        tick();
        bus.flit_wr = 1'b0;
        bus.flit_in = 8'h00;
    endtask

    initial begin
        bus.flit_in  = 8'h81;
        bus.flit_wr  = 1'b1;
        bus.pe_ready = 1'b0;
        bus2.flit_in = 8'h00;
        bus2.flit_wr = 1'b0;
        bus2.pe_ready = 1'b0;

        // 1: reset held two cycles with a live write presented
        rst = 1'b0;
        tick();
        tick();
        check("rst_pe_valid", bus.pe_valid, 0);
        check("rst_buf_full", bus.buf_full, 0);
        check("rst_pe_data", bus.pe_data, 0);
        check("rst_rx", rx_count, 0);
        check("rst_mis", misroute_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_rx2", rx2, 0);
        rst = 1'b1;
        bus.flit_wr = 1'b0;
        bus.flit_in = 8'h00;
        tick();

        // 2: single accepted flit, no same-cycle bypass
        bus.flit_wr = 1'b1;
        bus.flit_in = 8'h85;
        check("nobypass_valid", bus.pe_valid, 0);
        tick();
        bus.flit_wr = 1'b0;
        check("one_valid", bus.pe_valid, 1);
        check("one_data", bus.pe_data, 8'h85);
        check("one_rx", rx_count, 1);

        // 3: misrouted then invalid flit
        wr(8'h84);
        wr(8'h05);
        check("mis_count", misroute_count, 1);
        check("mis_rx", rx_count, 1);
        check("mis_drop", drop_count, 0);
        check("mis_head", bus.pe_data, 8'h85);
        bus.pe_ready = 1'b1;
        tick();
        bus.pe_ready = 1'b0;
        check("drain_valid", bus.pe_valid, 0);
        check("drain_data", bus.pe_data, 0);

        // 4: fill, overflow drop, then ordered drain
        wr(8'h81);
        wr(8'h85);
        wr(8'h89);
        check("three_not_full", bus.buf_full, 0);
        wr(8'h8D);
        check("full_flag", bus.buf_full, 1);
        check("full_rx", rx_count, 5);
        wr(8'h91);
        check("ovf_drop", drop_count, 1);
        check("ovf_rx", rx_count, 5);
        check("ovf_full", bus.buf_full, 1);
        bus.pe_ready = 1'b1;
        check("pop0", bus.pe_data, 8'h81);
        tick();
        check("pop1", bus.pe_data, 8'h85);
        check("pop1_not_full", bus.buf_full, 0);
        tick();
        check("pop2", bus.pe_data, 8'h89);
        tick();
        check("pop3", bus.pe_data, 8'h8D);
        tick();
        check("empty_valid", bus.pe_valid, 0);
        tick();
        check("empty_ready_valid", bus.pe_valid, 0);
        bus.pe_ready = 1'b0;

        // 5: full with simultaneous pop and write
        wr(8'h81);
        wr(8'h85);
        wr(8'h89);
        wr(8'h8D);
        check("refill_head", bus.pe_data, 8'h81);
        check("refill_rx", rx_count, 9);
        bus.pe_ready = 1'b1;
        wr(8'h95);
        check("sim_full", bus.buf_full, 1);
        check("sim_drop", drop_count, 1);
        check("sim_rx", rx_count, 10);
        check("sim_head", bus.pe_data, 8'h85);
        tick();
        check("sim_pop1", bus.pe_data, 8'h89);
        tick();
        check("sim_pop2", bus.pe_data, 8'h8D);
        tick();
        check("sim_pop3", bus.pe_data, 8'h95);
        tick();
        check("sim_empty", bus.pe_valid, 0);
        bus.pe_ready = 1'b0;

        // 6: reset discards buffered flits
        wr(8'h81);
        wr(8'h85);
        wr(8'h89);
        check("pre_rst_valid", bus.pe_valid, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", bus.pe_valid, 0);
        check("mid_rst_rx", rx_count, 0);
        check("mid_rst_mis", misroute_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_full", bus.buf_full, 0);
        wr(8'h99);
        check("post_rst_data", bus.pe_data, 8'h99);
        check("post_rst_rx", rx_count, 1);

        // Saturation on the CNT_W=4 instance: 17 flits to node 2 with continuous pops
        bus2.pe_ready = 1'b1;
        bus2.flit_wr  = 1'b1;
        bus2.flit_in  = 8'h82;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("sat_rx15", rx2, 15);
        tick();
        tick();
        bus2.flit_wr = 1'b0;
        check("sat_rx17", rx2, 15);
        check("sat_drop", drop2, 0);
        check("sat_occ", bus2.pe_valid, 1);
        tick();
        check("sat_empty", bus2.pe_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
